// File: rtl/bus_arbiter8_if.sv
// rtl/bus_arbiter8_if.sv - request/grant bundle between bus sources and the mux8 round-robin arbiter.
interface bus_arbiter8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] select;
  logic       busy;
  logic       owner_valid;

  modport master (output req, input grant, input select, input busy, input owner_valid);
  modport slave  (input req, output grant, output select, output busy, output owner_valid);
endinterface

// File: rtl/bus_arbiter8.sv
// rtl/bus_arbiter8.sv - 8-way round-robin bus arbiter with one-cycle turnaround, fully registered outputs.
// Define ARB_HOLD_LIMIT_EN to force an owner off the bus after MAX_HOLD consecutive grant cycles.
module bus_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_arbiter8_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t     state_q, state_d;
  logic [2:0] last_owner_q, last_owner_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] select_q, select_d;
  logic       busy_q, busy_d;
  logic       owner_valid_q, owner_valid_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       hold_hit;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("bus_arbiter8: MAX_HOLD must be within 1..255");
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;

  assign hold_hit = (hold_cnt_q == HOLD_LAST);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q != GRANT) begin
      hold_cnt_d = 8'd0;
    end else if (hold_cnt_q != 8'hFF) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  // Rotating search: start just above the previous owner so it ranks last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_owner_q;
    cand       = last_owner_q;
    for (int i = 0; i < 8; i++) begin
      cand = last_owner_q + 3'(i) + 3'd1;
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    grant_d       = grant_q;
    select_d      = select_q;
    busy_d        = busy_q;
    owner_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = GRANT;
          grant_d       = 8'b1 << pick_idx;
          select_d      = pick_idx;
          busy_d        = 1'b1;
          owner_valid_d = 1'b1;
          last_owner_d  = pick_idx;
        end
      end
      GRANT: begin
        if (!bus.req[last_owner_q] || hold_hit) begin
          state_d = TURN;
          grant_d = 8'h00;
          busy_d  = 1'b0;
        end
      end
      TURN: begin
        // select deliberately keeps the old owner so the mux does not glitch.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_owner_q  <= 3'd7;
      grant_q       <= 8'h00;
      select_q      <= 3'd0;
      busy_q        <= 1'b0;
      owner_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      grant_q       <= grant_d;
      select_q      <= select_d;
      busy_q        <= busy_d;
      owner_valid_q <= owner_valid_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.select      = select_q;
  assign bus.busy        = busy_q;
  assign bus.owner_valid = owner_valid_q;

endmodule
